// File: rtl/leds_rgb_pwm_if.sv
// Bus bundle for the registered RGB LED router.
// master drives pattern/buttons/duty; slave returns LED outputs.
interface leds_rgb_pwm_if #(
  parameter int N_LEDS   = 4,
  parameter int COLOR    = 3,
  parameter int PWM_BITS = 4
);
  logic [N_LEDS-1:0]   i_led;
  logic                i_valid;
  logic [COLOR-1:0]    i_btn;
  logic                i_clear;
  logic [PWM_BITS-1:0] i_duty;
  logic [COLOR-1:0]    o_led;
  logic [N_LEDS-1:0]   o_led_r;
  logic [N_LEDS-1:0]   o_led_g;
  logic [N_LEDS-1:0]   o_led_b;

  modport master (
    output i_led, i_valid, i_btn, i_clear, i_duty,
    input  o_led, o_led_r, o_led_g, o_led_b
  );

  modport slave (
    input  i_led, i_valid, i_btn, i_clear, i_duty,
    output o_led, o_led_r, o_led_g, o_led_b
  );
endinterface

// File: rtl/leds_rgb_pwm.sv
// Registered RGB LED router: per-channel patterns, sticky button
// channel select, global PWM dimming. Ports: i_clock, i_reset, bus.
module leds_rgb_pwm #(
  parameter int N_LEDS   = 4,
  parameter int COLOR    = 3,
  parameter int PWM_BITS = 4
) (
  input logic           i_clock,
  input logic           i_reset,
  leds_rgb_pwm_if.slave bus
);
  localparam logic [PWM_BITS-1:0] CNT_ONE = 1;

  logic [COLOR-1:0]    sync1, sync2, prev, sel;
  logic [COLOR-1:0]    btn_edge;
  logic [N_LEDS-1:0]   pat_r, pat_g, pat_b;
  logic [N_LEDS-1:0]   led_r, led_g, led_b;
  logic [PWM_BITS-1:0] pwm_cnt, duty_q;
  logic                pwm_on;

  assign btn_edge = sync2 & ~prev;
  // all-ones duty means a full period, not 15/16
  assign pwm_on = (duty_q == '1) | (pwm_cnt < duty_q);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      sel   <= '0;
    end else begin
      sync1 <= bus.i_btn;
      sync2 <= sync1;
      prev  <= sync2;
      // simultaneous presses are ambiguous: keep sel
      if ($onehot(btn_edge))
        sel <= btn_edge;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pat_r <= '0;
      pat_g <= '0;
      pat_b <= '0;
    end else if (bus.i_clear) begin
      pat_r <= '0;
      pat_g <= '0;
      pat_b <= '0;
    end else if (bus.i_valid) begin
      unique case (1'b1)
        sel[2]:  pat_r <= bus.i_led;
        sel[1]:  pat_g <= bus.i_led;
        sel[0]:  pat_b <= bus.i_led;
        default: ;
      endcase
    end
  end

  // duty only reloads on the period boundary
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pwm_cnt <= '0;
      duty_q  <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + CNT_ONE;
      if (pwm_cnt == '1)
        duty_q <= bus.i_duty;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      led_r <= '0;
      led_g <= '0;
      led_b <= '0;
    end else begin
      led_r <= pat_r & {N_LEDS{pwm_on}};
      led_g <= pat_g & {N_LEDS{pwm_on}};
      led_b <= pat_b & {N_LEDS{pwm_on}};
    end
  end

  assign bus.o_led   = sel;
  assign bus.o_led_r = led_r;
  assign bus.o_led_g = led_g;
  assign bus.o_led_b = led_b;
endmodule

// File: tb/tb_leds_rgb_pwm.sv
// Directed bench for leds_rgb_pwm.
// Reset, select, capture, clear, PWM duty, mid-op reset.
module tb_leds_rgb_pwm;
  logic clk = 1'b0;
  logic i_reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = 0;
  int   ons;

  leds_rgb_pwm_if #(.N_LEDS(4), .COLOR(3), .PWM_BITS(4)) bus ();

  leds_rgb_pwm #(.N_LEDS(4), .COLOR(3), .PWM_BITS(4)) dut (
    .i_clock (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // k = edges since the last reset edge
  task automatic step();
    logic r;
    r = i_reset;
    @(posedge clk);
    #1;
    if (r) k = 0;
    else k++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic capture(input logic [3:0] v);
    bus.i_led   = v;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    bus.i_led   = '0;
  endtask

  task automatic press(input logic [2:0] b);
    bus.i_btn = b;
    steps(3);
    bus.i_btn = '0;
    steps(3);
  endtask

  // expects k%16==0: covers pwm_cnt 0..15 of one period
  task automatic run_period(input int chg_at, input logic [3:0] nd,
                            output int n_on);
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == chg_at) bus.i_duty = nd;
      step();
      if (bus.o_led_r == 4'hF) n_on++;
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    bus.i_led   = '0;
    bus.i_valid = 1'b0;
    bus.i_btn   = '0;
    bus.i_clear = 1'b0;
    bus.i_duty  = '1;

    // 1: reset with toggling inputs
    for (int i = 0; i < 2; i++) begin
      bus.i_led   = 4'($urandom);
      bus.i_valid = 1'($urandom);
      bus.i_btn   = 3'($urandom);
      bus.i_clear = 1'($urandom);
      bus.i_duty  = 4'($urandom);
      step();
    end
    chk("rst_sel", 32'(bus.o_led), 0);
    chk("rst_r", 32'(bus.o_led_r), 0);
    chk("rst_g", 32'(bus.o_led_g), 0);
    chk("rst_b", 32'(bus.o_led_b), 0);
    i_reset     = 1'b0;
    bus.i_led   = '0;
    bus.i_valid = 1'b0;
    bus.i_btn   = '0;
    bus.i_clear = 1'b0;
    bus.i_duty  = '1;

    // 2: select red, 3-edge latency, capture
    bus.i_btn = 3'b100;
    step();
    chk("sel_e1", 32'(bus.o_led), 0);
    step();
    chk("sel_e2", 32'(bus.o_led), 0);
    step();
    chk("sel_e3", 32'(bus.o_led), 3'b100);
    bus.i_btn = '0;
    steps(3);
    chk("release", 32'(bus.o_led), 3'b100);
    capture(4'b1010);
    step();
    chk("cap_r", 32'(bus.o_led_r), 4'b1010);
    chk("cap_g", 32'(bus.o_led_g), 0);
    chk("cap_b", 32'(bus.o_led_b), 0);

    // 3: double press holds, single press moves
    press(3'b110);
    chk("dbl_hold", 32'(bus.o_led), 3'b100);
    press(3'b010);
    chk("sel_g", 32'(bus.o_led), 3'b010);
    capture(4'b0101);
    step();
    chk("cap_g2", 32'(bus.o_led_g), 4'b0101);
    chk("hold_r", 32'(bus.o_led_r), 4'b1010);
    press(3'b010);
    chk("repress", 32'(bus.o_led), 3'b010);

    // 4: clear beats capture
    press(3'b100);
    capture(4'b1111);
    step();
    chk("pre_clr_r", 32'(bus.o_led_r), 4'hF);
    bus.i_clear = 1'b1;
    capture(4'b1111);
    bus.i_clear = 1'b0;
    step();
    chk("clr_r", 32'(bus.o_led_r), 0);
    chk("clr_g", 32'(bus.o_led_g), 0);
    chk("clr_b", 32'(bus.o_led_b), 0);

    // 5: PWM duty
    capture(4'b1111);
    bus.i_duty = 4'd4;
    step();
    while (k % 16 != 0) step();
    run_period(-1, 4'd0, ons);
    chk("duty4", 32'(ons), 4);
    run_period(5, 4'd8, ons);
    chk("duty4_mid", 32'(ons), 4);
    run_period(-1, 4'd0, ons);
    chk("duty8", 32'(ons), 8);
    run_period(0, 4'd0, ons);
    chk("duty8_b", 32'(ons), 8);
    run_period(-1, 4'd0, ons);
    chk("duty0", 32'(ons), 0);
    run_period(0, 4'hF, ons);
    chk("duty0_b", 32'(ons), 0);
    run_period(-1, 4'd0, ons);
    chk("duty_full", 32'(ons), 16);

    // 6: reset mid-sync, mid-period
    bus.i_btn = 3'b001;
    steps(2);
    chk("pre_rst_r", 32'(bus.o_led_r), 4'hF);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("mrst_sel", 32'(bus.o_led), 0);
    chk("mrst_r", 32'(bus.o_led_r), 0);
    step();
    step();
    chk("resync_e2", 32'(bus.o_led), 0);
    step();
    chk("resync_e3", 32'(bus.o_led), 3'b001);
    capture(4'b0011);
    bus.i_duty = 4'd0;
    while (k < 16) step();
    chk("cnt_rst_b", 32'(bus.o_led_b), 4'b0011);
    chk("cnt_rst_r", 32'(bus.o_led_r), 0);
    step();
    chk("cnt_rst_off", 32'(bus.o_led_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
